// File: rtl/tag_lookup_if.sv
// tag_lookup_if: request/response handshake bundle for tag_lookup.
// master = requester side, slave = tag_lookup side.
interface tag_lookup_if #(
  parameter int NUM_SETS  = 4,
  parameter int ASSOC     = 4,
  parameter int TAG_WIDTH = 20
);
  localparam int SW = $clog2(NUM_SETS);
  localparam int WW = $clog2(ASSOC);

  logic                 req_valid;
  logic                 req_ready;
  logic [SW-1:0]        req_set;
  logic [TAG_WIDTH-1:0] req_tag;
  logic                 resp_valid;
  logic                 resp_ready;
  logic                 resp_hit;
  logic [WW-1:0]        resp_way;
  logic                 resp_evict_valid;
  logic [TAG_WIDTH-1:0] resp_evict_tag;

  modport master (
    output req_valid, req_set, req_tag, resp_ready,
    input  req_ready, resp_valid, resp_hit, resp_way,
    input  resp_evict_valid, resp_evict_tag
  );

  modport slave (
    input  req_valid, req_set, req_tag, resp_ready,
    output req_ready, resp_valid, resp_hit, resp_way,
    output resp_evict_valid, resp_evict_tag
  );
endinterface

// File: rtl/tag_lookup.sv
// tag_lookup: set-associative tag store and lookup/allocate controller.
// Define TAG_LOOKUP_FLUSH_EN to add the flush_req/flush_done engine.
module tag_lookup #(
  parameter  int NUM_SETS  = 4,
  parameter  int ASSOC     = 4,
  parameter  int TAG_WIDTH = 20,
  localparam int SW = $clog2(NUM_SETS),
  localparam int WW = $clog2(ASSOC)
) (
  input  logic          clk,
  input  logic          reset,
  tag_lookup_if.slave   bus,
  output logic [SW-1:0] lru_set,
  output logic [WW-1:0] lru_selected_way,
  output logic          lru_process,
`ifdef TAG_LOOKUP_FLUSH_EN
  input  logic          flush_req,
  output logic          flush_done,
`endif
  input  logic [WW-1:0] lru_victim_way
);

`ifdef TAG_LOOKUP_FLUSH_EN
  typedef enum logic [2:0] {
    IDLE, LOOKUP, ALLOCATE, RESPOND, FLUSH
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE, LOOKUP, ALLOCATE, RESPOND
  } state_t;
`endif

  state_t               st_q;
  logic                 rdy_q;
  logic [SW-1:0]        set_q;
  logic [TAG_WIDTH-1:0] tag_r;
  logic [ASSOC-1:0]     valid_q [NUM_SETS];
  logic [TAG_WIDTH-1:0] tag_q [NUM_SETS][ASSOC];
  logic                 rv_q;
  logic                 hit_q;
  logic                 ev_q;
  logic [WW-1:0]        way_q;
  logic [TAG_WIDTH-1:0] evt_q;
  logic [ASSOC-1:0]     hit_vec;
  logic [WW-1:0]        hit_way;
  logic [WW-1:0]        free_way;
  logic [WW-1:0]        victim;
  logic                 any_free;
  logic                 accept;
`ifdef TAG_LOOKUP_FLUSH_EN
  logic [SW-1:0]        fl_q;
`endif

`ifdef TAG_LOOKUP_FLUSH_EN
  assign bus.req_ready = rdy_q && !flush_req;
  assign flush_done    = (st_q == FLUSH) &&
                         (fl_q == SW'(NUM_SETS - 1));
`else
  assign bus.req_ready = rdy_q;
`endif

  assign accept               = bus.req_valid && bus.req_ready;
  assign bus.resp_valid       = rv_q;
  assign bus.resp_hit         = hit_q;
  assign bus.resp_way         = way_q;
  assign bus.resp_evict_valid = ev_q;
  assign bus.resp_evict_tag   = evt_q;
  assign lru_set = (st_q == IDLE) ? '0 : set_q;

  // Descending scan so the lowest matching index wins.
  always_comb begin
    hit_vec  = '0;
    hit_way  = '0;
    free_way = '0;
    any_free = 1'b0;
    for (int w = 0; w < ASSOC; w++) begin
      hit_vec[w] = valid_q[set_q][w] &&
                   (tag_q[set_q][w] == tag_r);
    end
    for (int w = ASSOC - 1; w >= 0; w--) begin
      if (hit_vec[w]) hit_way = WW'(w);
      if (!valid_q[set_q][w]) begin
        free_way = WW'(w);
        any_free = 1'b1;
      end
    end
    victim = any_free ? free_way : lru_victim_way;
  end

  always_comb begin
    lru_process      = 1'b0;
    lru_selected_way = '0;
    if (st_q == LOOKUP && |hit_vec) begin
      lru_process      = 1'b1;
      lru_selected_way = hit_way;
    end
    if (st_q == ALLOCATE) begin
      lru_process      = 1'b1;
      lru_selected_way = victim;
    end
  end

  always_ff @(posedge clk) begin
    if (st_q == ALLOCATE) tag_q[set_q][victim] <= tag_r;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st_q  <= IDLE;
      rdy_q <= 1'b0;
      set_q <= '0;
      tag_r <= '0;
      rv_q  <= 1'b0;
      hit_q <= 1'b0;
      ev_q  <= 1'b0;
      way_q <= '0;
      evt_q <= '0;
      for (int s = 0; s < NUM_SETS; s++) valid_q[s] <= '0;
`ifdef TAG_LOOKUP_FLUSH_EN
      fl_q  <= '0;
`endif
    end else begin
      unique case (st_q)
        IDLE: begin
`ifdef TAG_LOOKUP_FLUSH_EN
          if (flush_req) begin
            st_q  <= FLUSH;
            rdy_q <= 1'b0;
            fl_q  <= '0;
          end else
`endif
          if (accept) begin
            set_q <= bus.req_set;
            tag_r <= bus.req_tag;
            st_q  <= LOOKUP;
            rdy_q <= 1'b0;
          end else begin
            rdy_q <= 1'b1;
          end
        end
        LOOKUP: begin
          if (|hit_vec) begin
            hit_q <= 1'b1;
            way_q <= hit_way;
            ev_q  <= 1'b0;
            evt_q <= '0;
            rv_q  <= 1'b1;
            st_q  <= RESPOND;
          end else begin
            st_q  <= ALLOCATE;
          end
        end
        ALLOCATE: begin
          valid_q[set_q][victim] <= 1'b1;
          hit_q <= 1'b0;
          way_q <= victim;
          ev_q  <= valid_q[set_q][victim];
          evt_q <= valid_q[set_q][victim] ?
                   tag_q[set_q][victim] : '0;
          rv_q  <= 1'b1;
          st_q  <= RESPOND;
        end
        RESPOND: begin
          if (bus.resp_ready) begin
            rv_q  <= 1'b0;
            rdy_q <= 1'b1;
            st_q  <= IDLE;
          end
        end
`ifdef TAG_LOOKUP_FLUSH_EN
        FLUSH: begin
          valid_q[fl_q] <= '0;
          fl_q <= fl_q + SW'(1);
          if (fl_q == SW'(NUM_SETS - 1)) begin
            rdy_q <= 1'b1;
            st_q  <= IDLE;
          end
        end
`endif
        default: st_q <= IDLE;
      endcase
    end
  end

  // A duplicate tag within one set would light several hit bits.
  a_hit_onehot: assert property (
    @(posedge clk) disable iff (!reset)
    (st_q == LOOKUP) |-> $onehot0(hit_vec)
  );

endmodule

// File: tb/tb_tag_lookup.sv
// tb_tag_lookup: scoreboard bench for tag_lookup with a true-LRU
// stand-in for lru_counters and a behavioural cache reference model.
module tb_tag_lookup;
  localparam int NS = 4;
  localparam int AS = 4;
  localparam int TW = 20;
  localparam int SW = $clog2(NS);
  localparam int WW = $clog2(AS);

  typedef struct { bit hit; int way; bit ev; int evt; } exp_t;
  typedef struct { int s; int w; } lru_t;

  logic clk = 1'b0;
  logic reset;
  logic [SW-1:0] lru_set;
  logic [WW-1:0] lru_selected_way;
  logic lru_process;
  logic [WW-1:0] lru_victim_way;
`ifdef TAG_LOOKUP_FLUSH_EN
  logic flush_req;
  logic flush_done;
`endif

  tag_lookup_if #(.NUM_SETS(NS), .ASSOC(AS), .TAG_WIDTH(TW)) bus();

  tag_lookup #(.NUM_SETS(NS), .ASSOC(AS), .TAG_WIDTH(TW)) dut (
    .clk              (clk),
    .reset            (reset),
    .bus              (bus),
    .lru_set          (lru_set),
    .lru_selected_way (lru_selected_way),
    .lru_process      (lru_process),
`ifdef TAG_LOOKUP_FLUSH_EN
    .flush_req        (flush_req),
    .flush_done       (flush_done),
`endif
    .lru_victim_way   (lru_victim_way)
  );

  always #5 clk = ~clk;

  int n_asrt = 0;
  int n_fail = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int rise_cyc = 0;
  int n_acc = 0;
  int n_pulse = 0;
  int rr_mode = 0;
  logic rv_d = 1'b0;
  logic last_ev = 1'b0;
  int last_way = 0;
  int last_evt = 0;

  exp_t exp_q[$];
  lru_t lexp_q[$];
  bit mv [NS][AS];
  int mt [NS][AS];
  int pr [NS][$];
  int env_q [NS][$];
  logic [WW-1:0] env_victim [NS] = '{default: '0};
  int ev_tmp;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_asrt++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Reference: hit search, else lowest free way, else LRU of pr.
  task automatic predict(input int s, input int t);
    exp_t e;
    lru_t l;
    int w;
    int idx;
    w = -1;
    for (int i = 0; i < AS; i++)
      if (mv[s][i] && mt[s][i] == t) w = i;
    e.hit = (w >= 0);
    e.ev = 1'b0;
    e.evt = 0;
    if (w < 0) begin
      for (int i = AS - 1; i >= 0; i--)
        if (!mv[s][i]) w = i;
      if (w < 0) begin
        w = pr[s][0];
        e.ev = 1'b1;
        e.evt = mt[s][w];
      end
      mv[s][w] = 1'b1;
      mt[s][w] = t;
    end
    e.way = w;
    idx = -1;
    for (int i = 0; i < pr[s].size(); i++)
      if (pr[s][i] == w) idx = i;
    pr[s].delete(idx);
    pr[s].push_back(w);
    exp_q.push_back(e);
    l.s = s;
    l.w = w;
    lexp_q.push_back(l);
  endtask

  task automatic env_touch(input int s, input int w, output int vic);
    int idx;
    if (env_q[s].size() == 0)
      for (int i = 0; i < AS; i++) env_q[s].push_back(i);
    idx = -1;
    for (int i = 0; i < env_q[s].size(); i++)
      if (env_q[s][i] == w) idx = i;
    if (idx >= 0) env_q[s].delete(idx);
    env_q[s].push_back(w);
    vic = env_q[s][0];
  endtask

  task automatic mon_resp();
    exp_t e;
    if (exp_q.size() == 0) begin
      chk("resp_unexpected", 1, 0);
      return;
    end
    e = exp_q.pop_front();
    chk("resp_hit", bus.resp_hit, e.hit);
    chk("resp_way", bus.resp_way, e.way);
    chk("resp_evict_valid", bus.resp_evict_valid, e.ev);
    chk("resp_evict_tag", bus.resp_evict_tag, e.evt);
  endtask

  task automatic mon_lru();
    lru_t l;
    n_pulse++;
    if (lexp_q.size() == 0) begin
      chk("lru_unexpected", 1, 0);
      return;
    end
    l = lexp_q.pop_front();
    chk("lru_set", lru_set, l.s);
    chk("lru_way", lru_selected_way, l.w);
  endtask

  // Stand-in for lru_counters: true LRU, updated on each pulse.
  assign lru_victim_way = env_victim[lru_set];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset && lru_process) begin
      env_touch(int'(lru_set), int'(lru_selected_way), ev_tmp);
      env_victim[lru_set] <= WW'(ev_tmp);
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      rv_d <= bus.resp_valid;
      if (bus.resp_valid && !rv_d) rise_cyc <= cyc;
      chk("lru_idle_respond",
          lru_process && (bus.resp_valid || bus.req_ready), 0);
      if (lru_process) mon_lru();
      if (bus.resp_valid && bus.resp_ready) begin
        mon_resp();
        last_ev  <= bus.resp_evict_valid;
        last_way <= int'(bus.resp_way);
        last_evt <= int'(bus.resp_evict_tag);
      end
    end else begin
      rv_d <= 1'b0;
    end
  end

  initial begin
    bus.resp_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (rr_mode == 0) bus.resp_ready = 1'b1;
      else if (rr_mode == 1)
        bus.resp_ready = ($urandom_range(0, 3) != 0);
      else bus.resp_ready = 1'b0;
    end
  end

  task automatic issue(input int s, input int t);
    int n;
    n = 0;
    bus.req_valid = 1'b1;
    bus.req_set = SW'(s);
    bus.req_tag = TW'(t);
    @(negedge clk);
    while (!bus.req_ready) begin
      n++;
      if (n > 50) begin
        chk("accept_timeout", 0, 1);
        bus.req_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    predict(s, t);
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    n_acc++;
    bus.req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1);
  end

  initial begin
    int n;
    int sv[$];
    logic [TW+WW+1:0] cap;
    for (int s = 0; s < NS; s++)
      for (int i = 0; i < AS; i++) pr[s].push_back(i);
    reset = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_set = '0;
    bus.req_tag = '0;
`ifdef TAG_LOOKUP_FLUSH_EN
    flush_req = 1'b0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", bus.req_ready, 0);
    chk("rst_resp_valid", bus.resp_valid, 0);
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rel_req_ready", bus.req_ready, 1);
    chk("rel_resp_valid", bus.resp_valid, 0);
    chk("rel_resp_hit", bus.resp_hit, 0);
    chk("rel_resp_way", bus.resp_way, 0);
    chk("rel_evict_valid", bus.resp_evict_valid, 0);
    chk("rel_evict_tag", bus.resp_evict_tag, 0);
    chk("rel_lru_set", lru_set, 0);
    chk("rel_lru_way", lru_selected_way, 0);
    chk("rel_lru_process", lru_process, 0);
    @(posedge clk);
    #1;

    // Latency counts the accept edge as the first cycle.
    issue(2, 'hABC);
    drain();
    chk("lat_miss", rise_cyc - acc_cyc + 1, 3);
    issue(2, 'hABC);
    drain();
    chk("lat_hit", rise_cyc - acc_cyc + 1, 2);

    for (int t = 1; t <= 4; t++) issue(1, t);
    issue(1, 1);
    issue(1, 5);
    drain();
    chk("evict_way", last_way, 1);
    chk("evict_valid", last_ev, 1);
    chk("evict_tag", last_evt, 2);

    rr_mode = 2;
    issue(2, 'hABC);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.resp_valid && n < 10);
    chk("bp_valid", bus.resp_valid, 1);
    cap = {bus.resp_valid, bus.resp_hit, bus.resp_way,
           bus.resp_evict_tag};
    repeat (5) begin
      @(negedge clk);
      chk("bp_stable", {bus.resp_valid, bus.resp_hit, bus.resp_way,
                        bus.resp_evict_tag}, cap);
      chk("bp_req_ready", bus.req_ready, 0);
      chk("bp_lru_process", lru_process, 0);
    end
    rr_mode = 0;
    drain();

    sv = pr[3];
    issue(3, 'h55);
    @(posedge clk);
    #1 reset = 1'b0;
    #1;
    chk("mid_rst_resp_valid", bus.resp_valid, 0);
    chk("mid_rst_lru_process", lru_process, 0);
    chk("mid_rst_req_ready", bus.req_ready, 0);
    for (int s = 0; s < NS; s++)
      for (int i = 0; i < AS; i++) mv[s][i] = 1'b0;
    exp_q.delete();
    lexp_q.delete();
    pr[3] = sv;
    n_acc--;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    issue(3, 'h55);
    drain();
    chk("post_rst_way", last_way, 0);
    chk("post_rst_evict", last_ev, 0);

    rr_mode = 1;
    for (int k = 0; k < 300; k++)
      issue($urandom_range(0, NS - 1), $urandom_range(1, 6));
    rr_mode = 0;
    drain();

`ifdef TAG_LOOKUP_FLUSH_EN
    issue(0, 'h11);
    issue(0, 'h12);
    issue(1, 'h21);
    drain();
    flush_req = 1'b1;
    @(negedge clk);
    chk("flush_req_ready", bus.req_ready, 0);
    @(posedge clk);
    #1 flush_req = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!flush_done && n < 20);
    chk("flush_done_cycles", n, 4);
    for (int s = 0; s < NS; s++)
      for (int i = 0; i < AS; i++) mv[s][i] = 1'b0;
    @(posedge clk);
    #1;
    issue(0, 'h11);
    issue(1, 'h21);
    drain();
`endif

    repeat (2) @(posedge clk);
    chk("lru_pulse_count", n_pulse, n_acc);
    chk("lru_exp_empty", lexp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_asrt, n_fail);
    $finish;
  end
endmodule

// File: doc/tag_lookup.md
# tag_lookup

Set-associative tag store and lookup controller sitting directly upstream of `lru_counters`. It accepts one lookup request at a time, compares the request tag against every way of the addressed set, and reports hit or miss. On a miss it allocates a way, using the first invalid way or else the LRU victim supplied by `lru_counters`. It drives exactly one `process_lru_counters` pulse per lookup, so the LRU state always tracks the way touched.

## Interface
- `NUM_SETS`, 4: number of sets; power of two, ≥2.
- `ASSOC`, 4: ways per set; even, >1, matching the `lru_counters` instance.
- `TAG_WIDTH`, 20: stored tag width.
- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: asynchronous, active-low reset (low = reset).
- `req_valid`  in  1: lookup request present.
- `req_ready`  out  1: block can accept a request.
- `req_set`  in  $clog2(NUM_SETS): set index.
- `req_tag`  in  TAG_WIDTH: tag to look up or allocate.
- `resp_valid`  out  1: response present.
- `resp_ready`  in  1: consumer takes response.
- `resp_hit`  out  1: 1 = hit, 0 = miss with allocation.
- `resp_way`  out  $clog2(ASSOC): way hit or allocated.
- `resp_evict_valid`  out  1: miss replaced a valid line.
- `resp_evict_tag`  out  TAG_WIDTH: tag of replaced line (0 if none).
- `lru_set`  out  $clog2(NUM_SETS): set to `lru_counters.set`.
- `lru_selected_way`  out  $clog2(ASSOC): to `lru_counters.selected_way`.
- `lru_process`  out  1: to `lru_counters.process_lru_counters`.
- `lru_victim_way`  in  $clog2(ASSOC): from `lru_counters.victim_way`.

## Operation
- Storage: `valid[NUM_SETS][ASSOC]` is cleared by reset. `tag[NUM_SETS][ASSOC]` is not reset.
- FSM states: IDLE, LOOKUP, ALLOCATE, RESPOND, and FLUSH when configured.
- IDLE: `req_ready`=1. On `req_valid && req_ready`, register `req_set`/`req_tag` and go to LOOKUP.
- LOOKUP: compute hit vector `valid & (tag == req_tag)` for the registered set.
  - Hit: `lru_process`=1 for this cycle with `lru_selected_way`=hit way; latch `resp_hit`=1 and `resp_way`; go to RESPOND.
  - Miss: go to ALLOCATE.
- ALLOCATE: victim = lowest-index invalid way, or `lru_victim_way` when all ways are valid.
  - Write `tag`=req_tag and `valid`=1 for the victim.
  - Latch `resp_evict_valid`/`resp_evict_tag` from the old contents.
  - Pulse `lru_process` with `lru_selected_way`=victim; go to RESPOND.
- RESPOND: `resp_valid`=1. Response fields stay stable until `resp_ready`, then return to IDLE.
- `lru_set` is the registered set whenever it is not IDLE.
- `lru_process` is asserted exactly one cycle per accepted request, and never in IDLE or RESPOND.
- Assertion: the hit vector is `$onehot0` in LOOKUP. A duplicate tag within a set is a design error.

## Timing
- Reset values: `req_ready`=0 while reset is asserted, then 1 after release (IDLE).
- All other outputs reset to 0: `resp_valid`, `resp_hit`, `resp_way`, `resp_evict_valid`, `resp_evict_tag`, `lru_set`, `lru_selected_way`, `lru_process`.
- Latency, accept edge to `resp_valid`: hit 2 cycles; miss 3 cycles.
- Throughput: one request per 3 cycles (hit) or 4 cycles (miss) with `resp_ready` held high.
- `req_ready` is 0 outside IDLE. A request held during a busy period is accepted on the first IDLE cycle.
- Back-pressure: `resp_ready`=0 holds RESPOND indefinitely with no LRU activity.
- The new `valid`/`tag` are visible to the next lookup. Back-to-back requests to the same set and tag give a miss, then a hit.
- Reset asserted mid-operation: FSM returns to IDLE, all valid bits clear, and any pending response is dropped. The in-flight LRU pulse is discarded.

## Configuration
- `TAG_LOOKUP_FLUSH_EN` defined: adds input `flush_req` and output `flush_done`.
  - In IDLE, `flush_req`=1 takes priority over `req_valid`, with `req_ready`=0 in that cycle.
  - FLUSH clears one set's valid bits per cycle, for NUM_SETS cycles, with no `lru_process`.
  - `flush_done` pulses for one cycle on the last set, then the FSM returns to IDLE.
  - LRU state is untouched.
- Undefined: no flush ports, no FLUSH state. Only reset clears valid bits.

## Test plan
- Reset release, NUM_SETS=4, ASSOC=4 -> `req_ready`=1 and all other outputs 0.
- Lookup set 2, tag 0xABC on an empty cache -> miss, `resp_way`=0, `resp_evict_valid`=0 at accept+3. Repeat -> hit, way 0, at accept+2. One `lru_process` per request.
- Fill set 1 with tags 1,2,3,4, then touch tag 1 -> the next new tag 5 evicts way 1 (tag 2), `resp_evict_valid`=1, `resp_evict_tag`=2.
- Hold `resp_ready`=0 for 5 cycles -> `resp_valid` and fields stable, `req_ready`=0, no `lru_process`.
- Assert reset while in ALLOCATE -> `resp_valid`=0. After release, the same tag misses into way 0.
- With `TAG_LOOKUP_FLUSH_EN`: fill 2 sets, then `flush_req` -> `flush_done` 4 cycles later, and previous tags miss.
